// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - single-outstanding AXI4-Lite arbiter, fetch + data onto one memory port
//
// Shares one single-port memory between the CPU instruction-fetch port
// (read-only) and the CPU data port (read/write). One request is accepted
// at a time, replayed on the memory-side channels, and its response is
// routed back to the requester that issued it.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   f_ar*/f_r*           fetch read address / read data channels (slave)
//   d_ar*/d_r*           data read address / read data channels (slave)
//   d_aw*/d_w*/d_b*      data write address / write data / write response (slave)
//   m_*                  memory-side AR/R/AW/W/B channels (master)
//   busy                 arbiter is serving a transaction
//   grant_id             current owner: 0 none, 1 fetch read, 2 data read, 3 data write
//
// Build option: ARB_ROUND_ROBIN_EN selects round-robin between the fetch
// and data classes; undefined gives fixed data-over-fetch priority.

module axi_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   f_araddr,
  input  logic                    f_arvalid,
  output logic                    f_arready,
  output logic [DATA_WIDTH-1:0]   f_rdata,
  output logic [1:0]              f_rresp,
  output logic                    f_rvalid,
  input  logic                    f_rready,
  input  logic [ADDR_WIDTH-1:0]   d_araddr,
  input  logic                    d_arvalid,
  output logic                    d_arready,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic [1:0]              d_rresp,
  output logic                    d_rvalid,
  input  logic                    d_rready,
  input  logic [ADDR_WIDTH-1:0]   d_awaddr,
  input  logic                    d_awvalid,
  output logic                    d_awready,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  input  logic                    d_wvalid,
  output logic                    d_wready,
  output logic [1:0]              d_bresp,
  output logic                    d_bvalid,
  input  logic                    d_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic                    busy,
  output logic [1:0]              grant_id
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_FR   = 2'd1;
  localparam logic [1:0] GNT_DR   = 2'd2;
  localparam logic [1:0] GNT_DW   = 2'd3;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    arvalid_q, awvalid_q, wvalid_q, busy_q;
  logic [1:0]              grant_q;
  logic [1:0]              win;
  logic                    fr_req, dw_req, data_req;
  logic [1:0]              data_gnt;

  // A write needs AW and W together; a lone half is never accepted.
  assign fr_req   = f_arvalid;
  assign dw_req   = d_awvalid && d_wvalid;
  assign data_req = dw_req || d_arvalid;
  assign data_gnt = dw_req ? GNT_DW : GNT_DR;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the fetch class should win the next fetch/data tie.
  logic rr_fetch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_fetch <= 1'b1;
    end else if (win != GNT_NONE) begin
      rr_fetch <= (win != GNT_FR);
    end
  end
`endif

  // Winner in IDLE; readies are decoded straight from it.
  always_comb begin
    win = GNT_NONE;
    if (state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (fr_req && data_req) win = rr_fetch ? GNT_FR : data_gnt;
      else if (data_req)      win = data_gnt;
      else if (fr_req)        win = GNT_FR;
`else
      if (data_req)           win = data_gnt;
      else if (fr_req)        win = GNT_FR;
`endif
    end
  end

  assign f_arready = (win == GNT_FR);
  assign d_arready = (win == GNT_DR);
  assign d_awready = (win == GNT_DW);
  assign d_wready  = (win == GNT_DW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (win == GNT_FR || win == GNT_DR) next_state = RD_ADDR;
        else if (win == GNT_DW)             next_state = WR_ADDR;
      end
      RD_ADDR: if (m_arready) next_state = RD_DATA;
      RD_DATA: if (m_rvalid && m_rready) next_state = IDLE;
      // AW and W complete independently; leave once neither is still pending.
      WR_ADDR: if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) next_state = WR_RESP;
      WR_RESP: if (m_bvalid && d_bready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      grant_q   <= GNT_NONE;
    end else begin
      busy_q <= (next_state != IDLE);
      if (next_state == IDLE) grant_q <= GNT_NONE;
      if (win != GNT_NONE) begin
        grant_q   <= win;
        addr_q    <= (win == GNT_FR) ? f_araddr : (win == GNT_DR) ? d_araddr : d_awaddr;
        data_q    <= d_wdata;
        strb_q    <= d_wstrb;
        arvalid_q <= (win != GNT_DW);
        awvalid_q <= (win == GNT_DW);
        wvalid_q  <= (win == GNT_DW);
      end
      if (state == RD_ADDR && m_arready) arvalid_q <= 1'b0;
      if (state == WR_ADDR && m_awready) awvalid_q <= 1'b0;
      if (state == WR_ADDR && m_wready)  wvalid_q  <= 1'b0;
    end
  end

  assign m_araddr  = addr_q;
  assign m_arvalid = arvalid_q;
  assign m_awaddr  = addr_q;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = data_q;
  assign m_wstrb   = strb_q;
  assign m_wvalid  = wvalid_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

  // Responses are pure pass-through, gated onto the owner only.
  assign f_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign f_rresp  = m_rresp;
  assign d_rresp  = m_rresp;
  assign f_rvalid = (state == RD_DATA) && (grant_q == GNT_FR) && m_rvalid;
  assign d_rvalid = (state == RD_DATA) && (grant_q == GNT_DR) && m_rvalid;
  assign m_rready = (state == RD_DATA) && ((grant_q == GNT_FR) ? f_rready : d_rready);
  assign d_bresp  = m_bresp;
  assign d_bvalid = (state == WR_RESP) && m_bvalid;
  assign m_bready = (state == WR_RESP) && d_bready;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - self-checking bench for axi_mem_arbiter
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rst = 1'b1;
  logic [31:0] f_araddr = '0, d_araddr = '0, d_awaddr = '0, d_wdata = '0;
  logic        f_arvalid = 0, f_rready = 0, d_arvalid = 0, d_rready = 0;
  logic        d_awvalid = 0, d_wvalid = 0, d_bready = 0;
  logic [3:0]  d_wstrb = '0;
  logic        f_arready, f_rvalid, d_arready, d_rvalid, d_awready, d_wready, d_bvalid;
  logic [31:0] f_rdata, d_rdata;
  logic [1:0]  f_rresp, d_rresp, d_bresp, grant_id;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, busy;
  logic        m_arready = 1'b1, m_awready = 1'b1, m_wready = 1'b1;
  logic        m_rvalid, m_bvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] fq[$];
  logic [31:0] dq[$];
  logic [1:0]  bq[$];
  logic [1:0]  glog[$];
  logic        busy_prev = 1'b0;

  logic        rd_pend = 1'b0, b_pend = 1'b0;
  logic [31:0] rd_word = '0;
  int          aw_beats = 0, w_beats = 0, overlap = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  always #5 clk = ~clk;

  axi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .f_araddr(f_araddr), .f_arvalid(f_arvalid), .f_arready(f_arready),
    .f_rdata(f_rdata), .f_rresp(f_rresp), .f_rvalid(f_rvalid), .f_rready(f_rready),
    .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  // Zero-wait memory: R and B arrive the cycle after the address/data beat.
  always @(posedge clk or posedge mem_rst) begin
    if (mem_rst) begin
      rd_pend <= 1'b0;
      b_pend  <= 1'b0;
    end else begin
      if (m_arvalid && m_arready) begin
        rd_pend <= 1'b1;
        rd_word <= model_read(m_araddr);
        if (rd_pend || b_pend) overlap <= overlap + 1;
      end else if (m_rvalid && m_rready) begin
        rd_pend <= 1'b0;
      end
      if (m_awvalid && m_awready) begin
        aw_beats    <= aw_beats + 1;
        last_awaddr <= m_awaddr;
        if (rd_pend || b_pend) overlap <= overlap + 1;
      end
      if (m_wvalid && m_wready) begin
        w_beats    <= w_beats + 1;
        last_wdata <= m_wdata;
        last_wstrb <= m_wstrb;
        b_pend     <= 1'b1;
      end else if (m_bvalid && m_bready) begin
        b_pend <= 1'b0;
      end
    end
  end

  assign m_rvalid = rd_pend;
  assign m_rdata  = rd_word;
  assign m_rresp  = 2'b00;
  assign m_bvalid = b_pend;
  assign m_bresp  = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and grant logger.
  always @(negedge clk) begin
    if (rst) begin
      busy_prev <= 1'b0;
    end else begin
      if (busy && !busy_prev) glog.push_back(grant_id);
      busy_prev <= busy;
      if (f_rvalid && d_rvalid) check("both_rvalid", 1, 0);
      if (f_rvalid && f_rready) begin
        check("f_r_expected", fq.size() != 0, 1);
        if (fq.size() != 0) begin
          check("f_rdata", f_rdata, fq.pop_front());
          check("f_rresp", f_rresp, 0);
        end
      end
      if (d_rvalid && d_rready) begin
        check("d_r_expected", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          check("d_rdata", d_rdata, dq.pop_front());
          check("d_rresp", d_rresp, 0);
        end
      end
      if (d_bvalid && d_bready) begin
        check("d_b_expected", bq.size() != 0, 1);
        if (bq.size() != 0) check("d_bresp", d_bresp, bq.pop_front());
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || fq.size() != 0 || dq.size() != 0 || bq.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < 40, 1);
  endtask

  task automatic wait_grants(input string tag, input int cnt);
    int n = 0;
    while (glog.size() < cnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < 100, 1);
  endtask

  initial begin
    logic [1:0] exp_g[4];

    // Reset state
    @(negedge clk);
    check("rst_f_arready", f_arready, 0);
    check("rst_d_arready", d_arready, 0);
    check("rst_d_awready", d_awready, 0);
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_m_awvalid", m_awvalid, 0);
    check("rst_m_wvalid", m_wvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    rst = 1'b0;
    mem_rst = 1'b0;
    f_rready = 1'b1;
    d_rready = 1'b1;
    d_bready = 1'b1;

    // Lone fetch read
    @(posedge clk); #1;
    f_araddr = 32'h100;
    f_arvalid = 1'b1;
    fq.push_back(32'h0000_0013);
    @(negedge clk);
    check("fr_accept", f_arready, 1);
    check("fr_no_dready", d_arready, 0);
    @(posedge clk); #1;
    f_arvalid = 1'b0;
    @(negedge clk);
    check("fr_m_arvalid_n1", m_arvalid, 1);
    check("fr_m_araddr", m_araddr, 32'h100);
    check("fr_busy", busy, 1);
    check("fr_grant", grant_id, 1);
    @(negedge clk);
    check("fr_rvalid_n2", f_rvalid, 1);
    check("fr_d_rvalid", d_rvalid, 0);
    @(negedge clk);
    check("fr_idle_n3", busy, 0);
    check("fr_grant_none", grant_id, 0);

    // Data write with AW and W together
    @(posedge clk); #1;
    d_awaddr = 32'h2000;
    d_wdata = 32'hDEADBEEF;
    d_wstrb = 4'hF;
    d_awvalid = 1'b1;
    d_wvalid = 1'b1;
    bq.push_back(2'b00);
    @(negedge clk);
    check("dw_awready", d_awready, 1);
    check("dw_wready", d_wready, 1);
    @(posedge clk); #1;
    d_awvalid = 1'b0;
    d_wvalid = 1'b0;
    @(negedge clk);
    check("dw_m_awvalid", m_awvalid, 1);
    check("dw_m_wvalid", m_wvalid, 1);
    check("dw_grant", grant_id, 3);
    wait_idle("dw_done");
    check("dw_aw_beats", aw_beats, 1);
    check("dw_w_beats", w_beats, 1);
    check("dw_awaddr", last_awaddr, 32'h2000);
    check("dw_wdata", last_wdata, 32'hDEADBEEF);
    check("dw_wstrb", {28'h0, last_wstrb}, 32'hF);

    // AW without W: nothing accepted until W arrives
    @(posedge clk); #1;
    d_awaddr = 32'h2040;
    d_awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lone_aw_busy", busy, 0);
      check("lone_aw_ready", d_awready, 0);
    end
    @(posedge clk); #1;
    d_wdata = 32'h1234_5678;
    d_wstrb = 4'h3;
    d_wvalid = 1'b1;
    bq.push_back(2'b00);
    @(negedge clk);
    check("lone_aw_accept", d_wready, 1);
    @(posedge clk); #1;
    d_awvalid = 1'b0;
    d_wvalid = 1'b0;
    wait_idle("lone_aw_done");
    check("lone_aw_beats", aw_beats, 2);
    check("lone_w_beats", w_beats, 2);
    check("lone_wstrb", {28'h0, last_wstrb}, 32'h3);

    // FR and DR contending for four grants
    glog.delete();
    @(posedge clk); #1;
    f_araddr = 32'h300;
    d_araddr = 32'h400;
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{2'd1, 2'd2, 2'd1, 2'd2};
    fq.push_back(model_read(32'h300));
    fq.push_back(model_read(32'h300));
    dq.push_back(model_read(32'h400));
    dq.push_back(model_read(32'h400));
`else
    exp_g = '{2'd2, 2'd2, 2'd2, 2'd2};
    for (int i = 0; i < 4; i++) dq.push_back(model_read(32'h400));
`endif
    f_arvalid = 1'b1;
    d_arvalid = 1'b1;
    wait_grants("contend_wait", 4);
    @(posedge clk); #1;
    f_arvalid = 1'b0;
    d_arvalid = 1'b0;
    wait_idle("contend_done");
    for (int i = 0; i < 4; i++) check($sformatf("contend_grant%0d", i), glog[i], exp_g[i]);

    // DW beats DR
    glog.delete();
    @(posedge clk); #1;
    d_awaddr = 32'h2080;
    d_wdata = 32'hCAFE_F00D;
    d_wstrb = 4'hC;
    d_araddr = 32'h600;
    d_awvalid = 1'b1;
    d_wvalid = 1'b1;
    d_arvalid = 1'b1;
    bq.push_back(2'b00);
    dq.push_back(model_read(32'h600));
    @(negedge clk);
    check("dwdr_awready", d_awready, 1);
    check("dwdr_arready", d_arready, 0);
    @(posedge clk); #1;
    d_awvalid = 1'b0;
    d_wvalid = 1'b0;
    wait_grants("dwdr_wait", 2);
    @(posedge clk); #1;
    d_arvalid = 1'b0;
    wait_idle("dwdr_done");
    check("dwdr_grant0", glog[0], 3);
    check("dwdr_grant1", glog[1], 2);
    check("dwdr_wdata", last_wdata, 32'hCAFE_F00D);

    // Reset while a read response is being presented
    @(posedge clk); #1;
    f_araddr = 32'h500;
    f_rready = 1'b0;
    f_arvalid = 1'b1;
    @(negedge clk);
    check("rstmid_accept", f_arready, 1);
    @(posedge clk); #1;
    f_arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_rvalid_before", f_rvalid, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstmid_rvalid", f_rvalid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_grant", grant_id, 0);
    check("rstmid_m_arvalid", m_arvalid, 0);
    mem_rst = 1'b1;
    #1;
    mem_rst = 1'b0;
    f_rready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_rvalid", f_rvalid, 0);
      check("post_rst_busy", busy, 0);
    end
    check("no_overlap", overlap, 0);
    check("fq_empty", fq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Single-outstanding AXI4-Lite arbiter that shares one single-port external memory between the CPU instruction-fetch port (read-only) and the CPU data port (read/write). It sits between `soc_top` and `axi_memory` when the memory is built one-port (`MEM_DUAL_PORT=0`). It accepts one request at a time, replays it on the memory-side AXI channel, and routes the response back to the requester that issued it.

## Interface
- `ADDR_WIDTH`, 32, AXI address width on all ports
- `DATA_WIDTH`, 32, AXI data width on all ports (`DATA_WIDTH/8` strobe bits)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `f_araddr` in ADDR_WIDTH, `f_arvalid` in 1, `f_arready` out 1: fetch AR channel
- `f_rdata` out DATA_WIDTH, `f_rresp` out 2, `f_rvalid` out 1, `f_rready` in 1: fetch R channel
- `d_araddr`/`d_arvalid`/`d_arready`, `d_rdata`/`d_rresp`/`d_rvalid`/`d_rready`: data read channels, same widths as fetch
- `d_awaddr` in ADDR_WIDTH, `d_awvalid` in 1, `d_awready` out 1: data AW channel
- `d_wdata` in DATA_WIDTH, `d_wstrb` in DATA_WIDTH/8, `d_wvalid` in 1, `d_wready` out 1: data W channel
- `d_bresp` out 2, `d_bvalid` out 1, `d_bready` in 1: data B channel
- `m_*`: memory-side AR/R/AW/W/B channels, master direction, same widths
- `busy`  out 1: FSM not in IDLE
- `grant_id`  out 2: 0 = none, 1 = fetch read, 2 = data read, 3 = data write; holds the current owner

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- Candidates in IDLE: FR (`f_arvalid`), DR (`d_arvalid`), DW (`d_awvalid && d_wvalid`). DW is accepted only when AW and W are valid together; a lone AW or W is not accepted.
- The data class is DW if present, otherwise DR. DW beats DR unconditionally.
- Choice between the fetch and data classes depends on `ARB_ROUND_ROBIN_EN` (see Configuration).
- Accept: in IDLE, the winner's ready (`f_arready`, `d_arready`, or `d_awready` + `d_wready`) is driven high combinationally for that one cycle. Address, data and strobe are captured, and `grant_id` is set.
- Read path: IDLE → RD_ADDR.
  - In RD_ADDR, `m_arvalid`=1 with the captured address until `m_arready`, then → RD_DATA.
  - In RD_DATA, `m_rdata`/`m_rresp` pass combinationally to the granted master. `m_rvalid` is gated onto only that master's `rvalid`, and `m_rready` = that master's `rready`.
  - On the `m_rvalid && m_rready` beat → IDLE.
- Write path: IDLE → WR_ADDR.
  - `m_awvalid` and `m_wvalid` assert together and each drops independently on its own ready.
  - When both are done → WR_RESP. `m_bvalid`/`m_bresp` pass to `d_bvalid`/`d_bresp`, and `m_bready` = `d_bready`. The B handshake → IDLE.
- Ports that are not granted see ready=0 and valid=0. Response data on non-granted ports is don't-care.
- The memory side never has more than one transaction outstanding.

## Timing
- Reset values: all `*ready`/`*valid` outputs 0, `busy`=0, `grant_id`=0, FSM=IDLE, rr pointer = fetch-preferred.
- Reset mid-transaction: immediate return to IDLE. Any in-flight memory response is dropped; no master receives it.
- Request present in cycle N (IDLE) → accepted in N → `m_arvalid`/`m_awvalid` high in N+1.
- Minimum read occupancy, memory with zero wait: AR at N+1, R at N+2, IDLE at N+3. The next accept happens in N+3.
- Responses add zero latency; they are combinational pass-through in RD_DATA and WR_RESP.
- A master may hold valid through a busy period. Its request stays pending and is considered again at the next IDLE.
- `m_*valid`, `grant_id` and `busy` are registered. Master-side readies are combinational from FSM and valids only.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - When both classes request, the class not granted last time wins.
  - The pointer updates at each accept.
  - Starvation bound: the fetch port waits at most one data transaction.
- Undefined: fixed priority, data class over fetch. The pointer logic is removed.

## Test plan
- Lone fetch read, `f_araddr`=0x100, memory returns 0x00000013 → `f_rvalid` with 0x00000013 at N+2, and `d_rvalid` never asserts.
- Data write 0xDEADBEEF, strobe 0xF, to 0x2000, with AW and W valid together → one `m_aw` beat and one `m_w` beat, then `d_bvalid` with OKAY. `d_awready` and `d_wready` pulse in the same cycle.
- AW valid with W held low for 3 cycles → no accept until W is valid; `busy` stays 0 meanwhile.
- FR and DR both continuously valid for 4 grants:
  - With `ARB_ROUND_ROBIN_EN`: `grant_id` sequence 1,2,1,2.
  - Without it: 2,2,2,2.
- DW and DR valid together → `grant_id`=3 first, then 2.
- `rst` pulsed during RD_DATA while `m_rvalid`=1 → `f_rvalid`=0 from the reset cycle; `busy`=0 and `grant_id`=0.
